// File: rtl/ring_router_credit.sv
// One node of a bidirectional ring: three input FIFOs (east, west, local), credit-gated
// registered link outputs, a round-robin eject register and per-node traffic statistics.
module ring_router_credit #(
  parameter int unsigned NUM_NODES  = 4,
  parameter int unsigned ROUTER_ID  = 0,
  parameter int unsigned ID_W       = 16,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned STAT_W     = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TS_W-1:0]         clk_counter,
  input  logic [TS_W+2*ID_W:0]    link_east_in,
  input  logic [TS_W+2*ID_W:0]    link_west_in,
  input  logic                    credit_east_in,
  input  logic                    credit_west_in,
  output logic [TS_W+2*ID_W:0]    link_east_out,
  output logic [TS_W+2*ID_W:0]    link_west_out,
  output logic                    credit_east_out,
  output logic                    credit_west_out,
  input  logic [TS_W+2*ID_W:0]    inj_pkt,
  input  logic                    inj_valid,
  output logic                    inj_ready,
  output logic [TS_W+2*ID_W:0]    ej_pkt,
  output logic                    ej_valid,
  input  logic                    ej_ready,
  output logic [STAT_W-1:0]       stat_rx,
  output logic [STAT_W-1:0]       stat_lat,
  output logic [STAT_W-1:0]       stat_fwd,
  output logic                    err_overflow
);

  localparam int unsigned PKT_W = 1 + TS_W + 2 * ID_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FE    = 0;
  localparam int unsigned FW    = 1;
  localparam int unsigned FL    = 2;

  localparam logic [CW-1:0]   CrdMax = CW'(FIFO_DEPTH);
  localparam logic [AW:0]     CntMax = (AW + 1)'(FIFO_DEPTH);
  localparam logic [ID_W-1:0] MyId   = ID_W'(ROUTER_ID);
  localparam logic [ID_W:0]   NumN   = (ID_W + 1)'(NUM_NODES);

  typedef logic [PKT_W-1:0] pkt_t;

  pkt_t          mem_q    [3][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q [3];
  logic [AW-1:0] wr_ptr_q [3];
  logic [AW:0]   cnt_q    [3];
  pkt_t          push_pkt [3];
  pkt_t          head     [3];
  logic [2:0]    push, pop, full, avail, to_ej;
  logic          overflow;

  pkt_t              link_east_q, link_west_q, ej_pkt_q;
  logic              credit_east_q, credit_west_q, ej_valid_q, err_q;
  logic [CW-1:0]     crd_e_q, crd_e_d, crd_w_q, crd_w_d;
  logic              rr_e_q, rr_w_q;
  logic [1:0]        ej_ptr_q, ej_win;
  logic              ej_any, ej_load, ej_take;
  logic [STAT_W-1:0] stat_rx_q, stat_lat_q, stat_fwd_q;
  logic [TS_W-1:0]   ej_lat;

  logic [ID_W:0] loc_dist;
  logic          loc_bad, loc_e, loc_w;
  logic          tr_e, tr_w, sel_l_e, sel_l_w, send_e, send_w;

  always_comb begin
    push_pkt[FE] = link_east_in;
    push_pkt[FW] = link_west_in;
    // Local packets always enter as valid flits whatever the source drove on the MSB.
    push_pkt[FL] = inj_pkt | {1'b1, {(PKT_W - 1){1'b0}}};
    for (int i = 0; i < 3; i++) begin
      head[i]  = mem_q[i][rd_ptr_q[i]];
      avail[i] = cnt_q[i] != '0;
      full[i]  = cnt_q[i] == CntMax;
      to_ej[i] = avail[i] && (head[i][ID_W-1:0] == MyId);
    end
    push[FE] = link_east_in[PKT_W-1] && !full[FE];
    push[FW] = link_west_in[PKT_W-1] && !full[FW];
    push[FL] = inj_valid && !full[FL];
    overflow = (link_east_in[PKT_W-1] && full[FE]) || (link_west_in[PKT_W-1] && full[FW]);
  end

  assign inj_ready = !full[FL];

  // Local head: shortest direction on the ring, ties go east.
  always_comb begin
    loc_dist = {1'b0, head[FL][ID_W-1:0]} + NumN - {1'b0, MyId};
    if (loc_dist >= NumN) loc_dist = loc_dist - NumN;
    loc_bad = avail[FL] && !to_ej[FL] && ({1'b0, head[FL][ID_W-1:0]} >= NumN);
    loc_e   = avail[FL] && !to_ej[FL] && !loc_bad && (loc_dist <= (NumN >> 1));
    loc_w   = avail[FL] && !to_ej[FL] && !loc_bad && (loc_dist > (NumN >> 1));
  end

  always_comb begin
    tr_e    = avail[FW] && !to_ej[FW];
    tr_w    = avail[FE] && !to_ej[FE];
    sel_l_e = loc_e && (!tr_e || ((ARB_MODE != 0) && rr_e_q));
    sel_l_w = loc_w && (!tr_w || ((ARB_MODE != 0) && rr_w_q));
    send_e  = (crd_e_q != '0) && (tr_e || loc_e);
    send_w  = (crd_w_q != '0) && (tr_w || loc_w);
  end

  always_comb begin
    ej_any = 1'b0;
    ej_win = ej_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!ej_any && to_ej[(int'(ej_ptr_q) + k) % 3]) begin
        ej_any = 1'b1;
        ej_win = 2'((int'(ej_ptr_q) + k) % 3);
      end
    end
    ej_load = !ej_valid_q || ej_ready;
    ej_take = ej_load && ej_any;
  end

  always_comb begin
    pop[FE] = (send_w && !sel_l_w) || (ej_take && (ej_win == 2'd0));
    pop[FW] = (send_e && !sel_l_e) || (ej_take && (ej_win == 2'd1));
    pop[FL] = (send_e && sel_l_e) || (send_w && sel_l_w) || loc_bad ||
              (ej_take && (ej_win == 2'd2));
  end

  // A returned credit and a send in the same cycle cancel out.
  always_comb begin
    crd_e_d = crd_e_q;
    if (credit_east_in && !send_e && (crd_e_q != CrdMax)) crd_e_d = crd_e_q + 1'b1;
    else if (!credit_east_in && send_e)                   crd_e_d = crd_e_q - 1'b1;
    crd_w_d = crd_w_q;
    if (credit_west_in && !send_w && (crd_w_q != CrdMax)) crd_w_d = crd_w_q + 1'b1;
    else if (!credit_west_in && send_w)                   crd_w_d = crd_w_q - 1'b1;
  end

  assign ej_lat = clk_counter - ej_pkt_q[2*ID_W +: TS_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= push_pkt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      link_east_q   <= '0;
      link_west_q   <= '0;
      credit_east_q <= 1'b0;
      credit_west_q <= 1'b0;
      crd_e_q       <= CrdMax;
      crd_w_q       <= CrdMax;
      rr_e_q        <= 1'b0;
      rr_w_q        <= 1'b0;
      ej_ptr_q      <= '0;
      ej_valid_q    <= 1'b0;
      ej_pkt_q      <= '0;
      stat_rx_q     <= '0;
      stat_lat_q    <= '0;
      stat_fwd_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
      end
      link_east_q   <= send_e ? (sel_l_e ? head[FL] : head[FW]) : '0;
      link_west_q   <= send_w ? (sel_l_w ? head[FL] : head[FE]) : '0;
      credit_east_q <= pop[FE];
      credit_west_q <= pop[FW];
      crd_e_q       <= crd_e_d;
      crd_w_q       <= crd_w_d;
      if (send_e && tr_e && loc_e) rr_e_q <= !rr_e_q;
      if (send_w && tr_w && loc_w) rr_w_q <= !rr_w_q;
      if (ej_load) begin
        ej_valid_q <= ej_any;
        if (ej_any) begin
          ej_pkt_q <= head[ej_win];
          ej_ptr_q <= (ej_win == 2'd2) ? 2'd0 : ej_win + 2'd1;
        end
      end
      if (ej_valid_q && ej_ready) begin
        stat_rx_q  <= stat_rx_q + 1'b1;
        stat_lat_q <= stat_lat_q + STAT_W'(ej_lat);
      end
      stat_fwd_q <= stat_fwd_q + STAT_W'(send_e) + STAT_W'(send_w);
      err_q      <= err_q | overflow;
    end
  end

  assign link_east_out   = link_east_q;
  assign link_west_out   = link_west_q;
  assign credit_east_out = credit_east_q;
  assign credit_west_out = credit_west_q;
  assign ej_pkt          = ej_pkt_q;
  assign ej_valid        = ej_valid_q;
  assign stat_rx         = stat_rx_q;
  assign stat_lat        = stat_lat_q;
  assign stat_fwd        = stat_fwd_q;
  assign err_overflow    = err_q;

endmodule
